// File: rtl/usb_tx_top_level.sv
// rtl/usb_tx_top_level.sv - USB full-speed NRZI, bit-stuffing packet transmitter (SYNC, payload, EOP)
module usb_tx_top_level (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] tx_data,
  input  logic        transmit_empty,
  input  logic        transmit_start,
  output logic        d_plus_out,
  output logic        d_minus_out,
  output logic        read_enable,
  output logic        tx_error
);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;   // clock within the current bit period
  logic [3:0]  idx_q, idx_d;           // SYNC: bits launched so far; DATA: bit index; EOP_SE0: period count
  logic [2:0]  ones_q, ones_d;         // consecutive 1s launched onto the line
  logic [15:0] shift_q, shift_d;       // bit 0 is the data bit currently on the line
  logic        dp_q, dp_d;
  logic        dm_q, dm_d;
  logic        start_prev_q;
  logic        bit_end;
  logic        seq_end;
  logic        launch;
  logic        launch_bit;

  assign bit_end = (bit_cnt_q == 3'd7);

  // A data-carrying sequence ends on the last clock of its final bit, once no stuff bit is owed.
  assign seq_end = bit_end &&
                   ((state_q == SYNC  && idx_q == 4'd8) ||
                    (state_q == DATA  && idx_q == 4'd15 && ones_q != 3'd6) ||
                    (state_q == STUFF && idx_q == 4'd15));

  assign read_enable = seq_end && !transmit_empty;

  // Error on an empty payload at the end of SYNC, or on a fresh start request while busy.
  assign tx_error = (seq_end && transmit_empty && state_q == SYNC) ||
                    (state_q != IDLE && transmit_start && !start_prev_q);

  assign d_plus_out  = dp_q;
  assign d_minus_out = dm_q;

  // Next-state: bit timing, SYNC/data/stuff sequencing, EOP, and NRZI line encoding.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    ones_d     = ones_q;
    shift_d    = shift_q;
    dp_d       = dp_q;
    dm_d       = dm_q;
    launch     = 1'b0;
    launch_bit = 1'b0;

    if (state_q != IDLE) bit_cnt_d = bit_cnt_q + 3'd1;

    case (state_q)
      IDLE: begin
        // Preload the counter so the first SYNC bit is launched on the following edge.
        if (transmit_start) begin
          state_d   = SYNC;
          bit_cnt_d = 3'd7;
          idx_d     = 4'd0;
          ones_d    = 3'd0;
        end
      end
      SYNC: begin
        if (bit_end && idx_q != 4'd8) begin
          launch     = 1'b1;
          launch_bit = (idx_q == 4'd7);
          idx_d      = idx_q + 4'd1;
        end
      end
      DATA: begin
        if (bit_end && !seq_end) begin
          launch = 1'b1;
          if (ones_q == 3'd6) begin
            state_d    = STUFF;
            launch_bit = 1'b0;
          end else begin
            shift_d    = {1'b0, shift_q[15:1]};
            idx_d      = idx_q + 4'd1;
            launch_bit = shift_q[1];
          end
        end
      end
      STUFF: begin
        if (bit_end && !seq_end) begin
          state_d    = DATA;
          shift_d    = {1'b0, shift_q[15:1]};
          idx_d      = idx_q + 4'd1;
          launch     = 1'b1;
          launch_bit = shift_q[1];
        end
      end
      EOP_SE0: begin
        if (bit_end) begin
          if (idx_q == 4'd1) begin
            state_d = EOP_J;
            dp_d    = 1'b1;
            dm_d    = 1'b0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      EOP_J: begin
        if (bit_end) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (seq_end) begin
      idx_d = 4'd0;
      if (!transmit_empty) begin
        state_d    = DATA;
        shift_d    = tx_data;
        launch     = 1'b1;
        launch_bit = tx_data[0];
      end else begin
        state_d = EOP_SE0;
        dp_d    = 1'b0;
        dm_d    = 1'b0;
      end
    end

    // NRZI: a 0 toggles J/K, a 1 holds; stuffed zeros go through the same path.
    if (launch) begin
      ones_d = launch_bit ? ones_q + 3'd1 : 3'd0;
      if (!launch_bit) begin
        dp_d = dm_q;
        dm_d = dp_q;
      end
    end
  end

  // State and line registers; reset forces the line back to J at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 3'd0;
      idx_q        <= 4'd0;
      ones_q       <= 3'd0;
      shift_q      <= 16'h0000;
      dp_q         <= 1'b1;
      dm_q         <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      idx_q        <= idx_d;
      ones_q       <= ones_d;
      shift_q      <= shift_d;
      dp_q         <= dp_d;
      dm_q         <= dm_d;
      start_prev_q <= transmit_start;
    end
  end

endmodule

// File: tb/tb_usb_tx_top_level.sv
// tb/tb_usb_tx_top_level.sv - scoreboard bench for usb_tx_top_level
module tb_usb_tx_top_level;

  logic        clk;
  logic        n_rst;
  logic [15:0] tx_data;
  logic        transmit_empty;
  logic        transmit_start;
  logic        d_plus_out;
  logic        d_minus_out;
  logic        read_enable;
  logic        tx_error;

  int          n_cmp;
  int          n_fail;
  bit          mon_en;

  logic [1:0]  exp_line[$];
  int          exp_re[$];
  int          exp_err[$];
  logic [15:0] fifo[$];

  usb_tx_top_level dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .tx_data        (tx_data),
    .transmit_empty (transmit_empty),
    .transmit_start (transmit_start),
    .d_plus_out     (d_plus_out),
    .d_minus_out    (d_minus_out),
    .read_enable    (read_enable),
    .tx_error       (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [1:0] sym_code(input byte c);
    if (c == "J") return 2'b10;
    if (c == "K") return 2'b01;
    return 2'b00;
  endfunction

  // FIFO model: pops on an edge where read_enable was high, then presents the new head.
  initial begin : fifo_model
    bit rd;
    logic [15:0] tmp;
    tx_data = 16'h0000;
    transmit_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd = read_enable;
      @(posedge clk);
      #3;
      if (rd && fifo.size() > 0) tmp = fifo.pop_front();
      transmit_empty = (fifo.size() == 0);
      tx_data = (fifo.size() > 0) ? fifo[0] : 16'h0000;
    end
  end

  // Monitor: a packet begins when the line leaves J; every clock is then checked against the queues.
  initial begin : monitor
    logic [1:0] line;
    logic [1:0] sym;
    bit active;
    bit want;
    int k;
    active = 0;
    k = 0;
    forever begin
      @(negedge clk);
      line = {d_plus_out, d_minus_out};
      if (!mon_en || !n_rst) begin
        active = 0;
      end else begin
        if (!active && line != 2'b10) begin
          if (exp_line.size() == 0) check("idle_line", 32'(line), 32'(2'b10));
          else begin
            active = 1;
            k = 0;
          end
        end
        if (active) begin
          sym = exp_line.pop_front();
          check($sformatf("line_k%0d", k), 32'(line), 32'(sym));
          want = (exp_re.size() > 0 && exp_re[0] == k);
          if (want) exp_re.delete(0);
          check($sformatf("read_enable_k%0d", k), 32'(read_enable), 32'(want));
          want = (exp_err.size() > 0 && exp_err[0] == k);
          if (want) exp_err.delete(0);
          check($sformatf("tx_error_k%0d", k), 32'(tx_error), 32'(want));
          k++;
          if (exp_line.size() == 0) begin
            active = 0;
            check("read_enable_missing", exp_re.size(), 0);
            check("tx_error_missing", exp_err.size(), 0);
            exp_re.delete();
            exp_err.delete();
          end
        end else begin
          check("idle_read_enable", 32'(read_enable), 0);
          check("idle_tx_error", 32'(tx_error), 0);
        end
      end
    end
  end

  task automatic run_pkt(input string syms, input int nw, input logic [15:0] w0, input logic [15:0] w1,
                         input int re_a, input int re_b, input int err_k, input int busy_k);
    for (int i = 0; i < syms.len(); i++) begin
      if (syms[i] != " ") repeat (8) exp_line.push_back(sym_code(syms[i]));
    end
    if (re_a >= 0) exp_re.push_back(re_a);
    if (re_b >= 0) exp_re.push_back(re_b);
    if (err_k >= 0) exp_err.push_back(err_k);
    if (nw > 0) fifo.push_back(w0);
    if (nw > 1) fifo.push_back(w1);
    repeat (2) @(posedge clk);
    #1 transmit_start = 1'b1;
    @(posedge clk);
    #1 transmit_start = 1'b0;
    if (busy_k >= 0) begin
      repeat (busy_k + 1) @(posedge clk);
      #1 transmit_start = 1'b1;
      repeat (3) @(posedge clk);
      #1 transmit_start = 1'b0;
    end
    for (int c = 0; c < 3000 && exp_line.size() != 0; c++) @(posedge clk);
    if (exp_line.size() != 0) begin
      check("packet_timeout", exp_line.size(), 0);
      exp_line.delete();
      exp_re.delete();
      exp_err.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    n_cmp = 0;
    n_fail = 0;
    mon_en = 0;
    n_rst = 1'b0;
    transmit_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_d_plus", 32'(d_plus_out), 1);
      check("rst_d_minus", 32'(d_minus_out), 0);
      check("rst_read_enable", 32'(read_enable), 0);
      check("rst_tx_error", 32'(tx_error), 0);
    end
    @(posedge clk);
    #1 n_rst = 1'b1;
    transmit_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_line", 32'({d_plus_out, d_minus_out}), 32'(2'b10));
    mon_en = 1;

    run_pkt("KJKJKJKK KKKKKJJJJ KJKJKJKJ SSJ", 1, 16'h00FF, 16'h0000, 63, -1, -1, -1);
    run_pkt("KJKJKJKK JJKKJJKKJJKKJJKK KJJKKJJKKJJKKJJK SSJ", 2, 16'hAAAA, 16'h5555, 63, 191, 99, 99);
    run_pkt("KJKJKJKK KKKKKJJJJJJJKKKKKK SSJ", 1, 16'hFFFF, 16'h0000, 63, -1, -1, -1);
    run_pkt("KJKJKJKK JKJKJKJKJK KKKKKK J J KJKJKJKJKJKJKJK SSJ", 2, 16'hFC00, 16'h0001, 63, 199, -1, -1);
    run_pkt("KJKJKJKK SSJ", 0, 16'h0000, 16'h0000, -1, -1, 63, -1);

    mon_en = 0;
    fifo.push_back(16'h00FF);
    repeat (2) @(posedge clk);
    #1 transmit_start = 1'b1;
    @(posedge clk);
    #1 transmit_start = 1'b0;
    repeat (100) @(posedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("midrst_d_plus", 32'(d_plus_out), 1);
    check("midrst_d_minus", 32'(d_minus_out), 0);
    check("midrst_read_enable", 32'(read_enable), 0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    fifo.delete();
    repeat (3) @(posedge clk);
    #1 mon_en = 1;
    run_pkt("KJKJKJKK SSJ", 0, 16'h0000, 16'h0000, -1, -1, 63, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
